// File: rtl/input_conditioner_if.sv
// Raw board inputs and conditioned outputs of the multiplier front-end.
// The slave side is the conditioner; the master side is the board/control unit.
interface input_conditioner_if;
  logic [7:0] Switches;
  logic       ClearALoadB_n;
  logic       Execute_n;
  logic [7:0] Switches_S;
  logic       ClearALoadB_SH;
  logic       Execute_SH;
  logic       ClearALoadB_P;
  logic       Execute_P;

  modport master (
    output Switches,
    output ClearALoadB_n,
    output Execute_n,
    input  Switches_S,
    input  ClearALoadB_SH,
    input  Execute_SH,
    input  ClearALoadB_P,
    input  Execute_P
  );

  modport slave (
    input  Switches,
    input  ClearALoadB_n,
    input  Execute_n,
    output Switches_S,
    output ClearALoadB_SH,
    output Execute_SH,
    output ClearALoadB_P,
    output Execute_P
  );
endinterface

// File: rtl/input_conditioner.sv
// Synchronizes switches and two active-low keys; keys are debounced and turned into
// one-cycle press pulses, with ClearALoadB taking priority over Execute.
module input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16
) (
  input logic                Clk,
  input logic                Reset,
  input_conditioner_if.slave io
);

  localparam int unsigned     KeyClr = 0;
  localparam int unsigned     KeyExe = 1;
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [7:0]       sw_s1_q, sw_s2_q;
  logic [1:0]       raw_key;
  logic [1:0]       key_s1_q, key_s2_q;
  logic [1:0]       stable_q, stable_d;
  logic [1:0]       prev_q;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];
  logic             clr_p_q, clr_p_d;
  logic             exe_p_q, exe_p_d;

  // Keys are inverted before the first flop so every internal key signal is active-high.
  assign raw_key = {~io.Execute_n, ~io.ClearALoadB_n};

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      key_s1_q <= '0;
      key_s2_q <= '0;
    end else begin
      sw_s1_q  <= io.Switches;
      sw_s2_q  <= sw_s1_q;
      key_s1_q <= raw_key;
      key_s2_q <= key_s1_q;
    end
  end

  // Any sample agreeing with the stable state restarts the count, so bounces never accumulate.
  always_comb begin
    stable_d = stable_q;
    for (int k = 0; k < 2; k++) begin
      cnt_d[k] = '0;
      if (key_s2_q[k] != stable_q[k]) begin
        if (cnt_q[k] == CntMax) begin
          stable_d[k] = key_s2_q[k];
        end else begin
          cnt_d[k] = cnt_q[k] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    clr_p_d = stable_q[KeyClr] & ~prev_q[KeyClr];
    // Execute press is dropped (not deferred) when Clear pulses or is held that cycle.
    exe_p_d = stable_q[KeyExe] & ~prev_q[KeyExe] & ~clr_p_d & ~stable_d[KeyClr];
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      stable_q <= '0;
      prev_q   <= '0;
      cnt_q    <= '{default: '0};
      clr_p_q  <= 1'b0;
      exe_p_q  <= 1'b0;
    end else begin
      stable_q <= stable_d;
      prev_q   <= stable_q;
      cnt_q    <= cnt_d;
      clr_p_q  <= clr_p_d;
      exe_p_q  <= exe_p_d;
    end
  end

  assign io.Switches_S     = sw_s2_q;
  assign io.ClearALoadB_SH = stable_q[KeyClr];
  assign io.Execute_SH     = stable_q[KeyExe];
  assign io.ClearALoadB_P  = clr_p_q;
  assign io.Execute_P      = exe_p_q;

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Front-end stage feeding the multiplier processor. Conditions the raw board inputs before they reach the control unit and register unit.
- Raw inputs are the 8 slide switches plus two active-low push keys (ClearALoadB, Execute).
- Per key: 2-flop synchronizer, counter-based debouncer and rising-edge one-shot.
- Switches: 2-flop synchronizer only.

Parameters:
- DEBOUNCE_CYCLES, 50000, consecutive synchronized samples that must disagree with the stable state before it flips (1 ms at 50 MHz).
- CNT_W, 16, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- Clk  input  1  system clock; all flops rising-edge.
- Reset  input  1  asynchronous, active-low reset.
- Switches  input  8  raw slide switches, asynchronous.
- ClearALoadB_n  input  1  raw key, active-low (pressed = 0), asynchronous.
- Execute_n  input  1  raw key, active-low, asynchronous.
- Switches_S  output  8  synchronized switches.
- ClearALoadB_SH  output  1  debounced level, active-high (1 = pressed).
- Execute_SH  output  1  debounced level, active-high.
- ClearALoadB_P  output  1  one-cycle pulse on debounced press.
- Execute_P  output  1  one-cycle pulse on debounced press, subject to the ClearALoadB priority rule.

Behaviour:
- Reset (Reset = 0, asynchronous):
  - All sync flops = 0 and Switches_S = 0.
  - Key sync flops hold the inverted (active-high) value, so they reset to 0 = released.
  - Stable states = 0, counters = 0, all _SH and _P outputs = 0.
- Reset release: synchronous to Clk; the first active edge is the first edge with Reset = 1.
- Switch path:
  - Switches_S = Switches delayed by exactly 2 Clk edges.
  - No debounce; each bit is synchronized independently, so bits may skew by one cycle.
- Key path, per key, identical and independent:
  - s1 <= ~raw; s2 <= s1. s2 is the synchronized active-high sample.
  - If s2 == stable: counter <= 0.
  - If s2 != stable and counter == DEBOUNCE_CYCLES-1: stable <= s2, counter <= 0.
  - If s2 != stable otherwise: counter <= counter + 1.
  - Any single-cycle agreement (bounce) clears the counter. Debouncing is symmetric for press and release.
  - _SH = stable (registered).
  - Latency from raw edge to _SH change: DEBOUNCE_CYCLES + 2 Clk edges for a clean input.
  - The counter never exceeds DEBOUNCE_CYCLES-1 and cannot wrap.
- Pulse generation:
  - prev <= stable.
  - Raw pulse = stable & ~prev, registered. It asserts for exactly 1 cycle, one cycle after _SH rises.
  - Release produces no pulse.
- Simultaneous events:
  - If ClearALoadB_P and Execute's raw pulse would assert on the same cycle, ClearALoadB_P = 1 and Execute_P = 0. That Execute press is dropped, not deferred.
  - Execute_P is also suppressed on any cycle where ClearALoadB_SH = 1. Execute_SH is unaffected.
- Key held at reset release: debounces normally, then produces one press pulse (DEBOUNCE_CYCLES + 3 edges after release).
- Reset mid-debounce: counter cleared and stable forced to 0. Any pulse in flight is cleared immediately (asynchronous).
- Outputs are glitch-free registered signals, safe to drive the control unit's Reset/Run inputs directly.

Test Plan:
All scenarios use a DEBOUNCE_CYCLES = 4 override.
- Reset: assert Reset = 0 mid-run with Execute pressed and counter nonzero -> all outputs 0 in the same cycle; after release with keys released, outputs stay 0.
- Switches: drive Switches = 8'hA5 at a Clk edge -> Switches_S = 8'hA5 exactly 2 edges later. Then 8'h3C -> 8'h3C 2 edges later, with no intermediate value.
- Clean press: Execute_n 1->0 and held -> Execute_SH = 1 after 6 edges; Execute_P = 1 for exactly 1 cycle on edge 7. Release -> Execute_SH = 0 after 6 edges, no pulse.
- Bounce: Execute_n pattern 0,0,0,1,0,0,0,1 (one value per cycle) -> Execute_SH never asserts. Then a steady 0 -> asserts 4 disagreeing samples later.
- Priority: press both keys on the same cycle -> ClearALoadB_P = 1, Execute_P = 0 throughout. Hold ClearALoadB, release and re-press Execute -> Execute_SH toggles, Execute_P stays 0.
- Held-at-reset: Execute_n = 0 during reset, then release reset -> a single Execute_P at edge 7, no second pulse while held.
